// File: rtl/simd_mult_pkg.sv
// Shared types for the SIMD multiply-accumulate path: precision modes, sequencer states, lane count.
// Pure declarations, no timing or flow control of its own.
// Imported by the sequencer top.
package simd_mult_pkg;

    typedef enum logic [1:0] {
        MODE_INT8 = 2'd0,
        MODE_INT4 = 2'd1,
        MODE_INT2 = 2'd2,
        MODE_RSVD = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int MAX_LANES = 4;

    // Number of live accumulator lanes for a precision mode; 0 for the reserved encoding.
    function automatic logic [2:0] lane_count(input mode_e mode);
        case (mode)
            MODE_INT8: lane_count = 3'd1;
            MODE_INT4: lane_count = 3'd2;
            MODE_INT2: lane_count = 3'd4;
            default:   lane_count = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/eight_bit_multiplier.sv
// Unsigned 8x8 multiplier with packed INT4 (2 lanes) and INT2 (4 lanes) sub-products.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow the operands.
module eight_bit_multiplier (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] result,
    output logic [7:0]  result_int4_0,
    output logic [7:0]  result_int4_1,
    output logic [3:0]  result_int2_0,
    output logic [3:0]  result_int2_1,
    output logic [3:0]  result_int2_2,
    output logic [3:0]  result_int2_3
);

    assign result        = {8'd0, a} * {8'd0, b};
    assign result_int4_0 = {4'd0, a[3:0]} * {4'd0, b[3:0]};
    assign result_int4_1 = {4'd0, a[7:4]} * {4'd0, b[7:4]};
    assign result_int2_0 = {2'd0, a[1:0]} * {2'd0, b[1:0]};
    assign result_int2_1 = {2'd0, a[3:2]} * {2'd0, b[3:2]};
    assign result_int2_2 = {2'd0, a[5:4]} * {2'd0, b[5:4]};
    assign result_int2_3 = {2'd0, a[7:6]} * {2'd0, b[7:6]};

endmodule

// File: rtl/simd_mac_sequencer.sv
// Job sequencer turning the SIMD multiplier into a lane-wise dot-product engine.
// Latency: last operand beat accepted at t -> out_valid at t+2; zero-length job -> out_valid at t+1.
// Backpressure: in_ready only in RUN; result held in DONE until out_ready.
module simd_mac_sequencer
    import simd_mult_pkg::*;
#(
    parameter int ACC_W = 24
) (
    input  logic                         CLK,
    input  logic                         nrst,
    input  logic                         cfg_start,
    input  logic [1:0]                   cfg_mode,
    input  logic [7:0]                   cfg_len,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [7:0]                   in_a,
    input  logic [7:0]                   in_b,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [MAX_LANES*ACC_W-1:0]   out_acc,
    output logic                         out_ovf,
    output logic                         busy,
    output logic                         cfg_err
);

    state_e             state;
    mode_e              mode_q;
    logic [7:0]         beats_left;
    logic               s1_vld;
    logic [7:0]         s1_a;
    logic [7:0]         s1_b;
    logic [ACC_W-1:0]   acc [MAX_LANES];
    logic               ovf_q;
    logic               cfg_err_q;

    logic [15:0]        mul_result;
    logic [7:0]         mul_int4 [2];
    logic [3:0]         mul_int2 [4];
    logic [ACC_W-1:0]   lane_prod [MAX_LANES];
    logic [ACC_W:0]     lane_sum [MAX_LANES];
    logic               wrap_any;

    logic               start_ok;
    logic               start_bad;
    logic               beat_acc;

    assign start_ok  = (state == ST_IDLE) && cfg_start && (mode_e'(cfg_mode) != MODE_RSVD);
    assign start_bad = (state == ST_IDLE) && cfg_start && (mode_e'(cfg_mode) == MODE_RSVD);
    assign beat_acc  = in_valid && in_ready;

    assign in_ready  = (state == ST_RUN);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);
    assign out_ovf   = ovf_q;
    assign cfg_err   = cfg_err_q;

    eight_bit_multiplier u_mult (
        .a             (s1_a),
        .b             (s1_b),
        .result        (mul_result),
        .result_int4_0 (mul_int4[0]),
        .result_int4_1 (mul_int4[1]),
        .result_int2_0 (mul_int2[0]),
        .result_int2_1 (mul_int2[1]),
        .result_int2_2 (mul_int2[2]),
        .result_int2_3 (mul_int2[3])
    );

    // Route multiplier outputs to lanes by the latched mode, zero-extended to ACC_W.
    always_comb begin
        for (int k = 0; k < MAX_LANES; k++) begin
            lane_prod[k] = '0;
        end
        case (mode_q)
            MODE_INT8: lane_prod[0] = ACC_W'(mul_result);
            MODE_INT4: begin
                lane_prod[0] = ACC_W'(mul_int4[0]);
                lane_prod[1] = ACC_W'(mul_int4[1]);
            end
            MODE_INT2: begin
                for (int k = 0; k < MAX_LANES; k++) begin
                    lane_prod[k] = ACC_W'(mul_int2[k]);
                end
            end
            default: ;
        endcase
    end

    // One extra bit per lane captures the carry that signals a wrap.
    always_comb begin
        wrap_any = 1'b0;
        for (int k = 0; k < MAX_LANES; k++) begin
            lane_sum[k] = {1'b0, acc[k]} + {1'b0, lane_prod[k]};
            wrap_any    = wrap_any | lane_sum[k][ACC_W];
        end
    end

    for (genvar k = 0; k < MAX_LANES; k++) begin : g_out
        localparam logic [2:0] LANE_IDX = 3'(k);
        assign out_acc[k*ACC_W +: ACC_W] = (LANE_IDX < lane_count(mode_q)) ? acc[k] : '0;
    end

    always_ff @(posedge CLK or negedge nrst) begin
        if (!nrst) begin
            state      <= ST_IDLE;
            mode_q     <= MODE_INT8;
            beats_left <= '0;
            s1_vld     <= 1'b0;
            s1_a       <= '0;
            s1_b       <= '0;
            cfg_err_q  <= 1'b0;
        end else begin
            cfg_err_q <= start_bad;
            s1_vld    <= beat_acc;
            if (beat_acc) begin
                s1_a <= in_a;
                s1_b <= in_b;
            end
            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        mode_q     <= mode_e'(cfg_mode);
                        beats_left <= cfg_len;
                        state      <= (cfg_len == 8'd0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (beat_acc) begin
                        beats_left <= beats_left - 8'd1;
                        if (beats_left == 8'd1) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // The last beat is in stage 1 now; its add lands on this edge.
                    if (s1_vld) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nrst) begin
        if (!nrst) begin
            for (int k = 0; k < MAX_LANES; k++) begin
                acc[k] <= '0;
            end
            ovf_q <= 1'b0;
        end else if (start_ok) begin
            for (int k = 0; k < MAX_LANES; k++) begin
                acc[k] <= '0;
            end
            ovf_q <= 1'b0;
        end else if (s1_vld) begin
            for (int k = 0; k < MAX_LANES; k++) begin
                acc[k] <= lane_sum[k][ACC_W-1:0];
            end
            if (wrap_any) begin
                ovf_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_simd_mac_sequencer.sv
// Self-checking bench for simd_mac_sequencer: 24-bit and 16-bit accumulator instances side by side.
module tb_simd_mac_sequencer;

    logic        CLK = 1'b0;
    logic        nrst = 1'b1;
    logic        cfg_start = 1'b0;
    logic [1:0]  cfg_mode = 2'd0;
    logic [7:0]  cfg_len = 8'd0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_a = 8'd0;
    logic [7:0]  in_b = 8'd0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, out_ovf, busy, cfg_err;
    logic [95:0] out_acc;
    logic        in_ready16, out_valid16, out_ovf16, busy16, cfg_err16;
    logic [63:0] out_acc16;

    always #5 CLK = ~CLK;

    simd_mac_sequencer #(.ACC_W(24)) dut (
        .CLK(CLK), .nrst(nrst), .cfg_start(cfg_start), .cfg_mode(cfg_mode), .cfg_len(cfg_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc), .out_ovf(out_ovf),
        .busy(busy), .cfg_err(cfg_err)
    );

    simd_mac_sequencer #(.ACC_W(16)) dut16 (
        .CLK(CLK), .nrst(nrst), .cfg_start(cfg_start), .cfg_mode(cfg_mode), .cfg_len(cfg_len),
        .in_valid(in_valid), .in_ready(in_ready16), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid16), .out_ready(out_ready), .out_acc(out_acc16), .out_ovf(out_ovf16),
        .busy(busy16), .cfg_err(cfg_err16)
    );

    typedef struct {
        logic [1:0]  mode;
        int          len;
        logic [7:0]  a;
        logic [7:0]  b;
        int          gap;
        int          hold;
        bit          poke;
        logic [95:0] acc;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic [95:0] acc24;
        logic        ovf24;
        logic [63:0] acc16;
        logic        ovf16;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic add_vec(input logic [1:0] m, input int len, input logic [7:0] a, input logic [7:0] b,
                           input int gap, input int hold, input bit poke,
                           input logic [23:0] l3, input logic [23:0] l2, input logic [23:0] l1, input logic [23:0] l0);
        vec_t v;
        v.mode = m; v.len = len; v.a = a; v.b = b;
        v.gap = gap; v.hold = hold; v.poke = poke;
        v.acc = {l3, l2, l1, l0};
        v.ovf = 1'b0;
        vecs.push_back(v);
    endtask

    // Expected 16-bit lanes derived from full-precision per-lane totals.
    function automatic exp_t model(input vec_t v);
        exp_t        e;
        logic [31:0] p;
        logic [31:0] tot;
        e.acc24 = v.acc;
        e.ovf24 = v.ovf;
        e.acc16 = '0;
        e.ovf16 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            p = 32'd0;
            case (v.mode)
                2'd0: if (k == 0) p = 32'(v.a) * 32'(v.b);
                2'd1: if (k < 2) p = 32'(v.a[4*k +: 4]) * 32'(v.b[4*k +: 4]);
                2'd2: p = 32'(v.a[2*k +: 2]) * 32'(v.b[2*k +: 2]);
                default: p = 32'd0;
            endcase
            tot = p * 32'(v.len);
            e.acc16[16*k +: 16] = tot[15:0];
            if (tot > 32'h0000_FFFF) e.ovf16 = 1'b1;
        end
        return e;
    endfunction

    task automatic check_result(input string tag, input exp_t e);
        check({tag, " out_valid"},   out_valid,   1'b1);
        check({tag, " out_acc"},     out_acc,     e.acc24);
        check({tag, " out_ovf"},     out_ovf,     e.ovf24);
        check({tag, " out_valid16"}, out_valid16, 1'b1);
        check({tag, " out_acc16"},   out_acc16,   e.acc16);
        check({tag, " out_ovf16"},   out_ovf16,   e.ovf16);
    endtask

    task automatic run_job(input string tag, input vec_t v);
        exp_t e;
        int   lat;
        int   waitc;
        sb.push_back(model(v));
        cfg_mode  = v.mode;
        cfg_len   = v.len[7:0];
        cfg_start = 1'b1;
        tick;
        cfg_start = 1'b0;
        check({tag, " busy after start"}, busy, 1'b1);
        if (v.len == 0) begin
            check({tag, " len0 out_valid at t+1"}, out_valid, 1'b1);
        end else begin
            for (int i = 0; i < v.len; i++) begin
                in_a = v.a;
                in_b = v.b;
                in_valid = 1'b1;
                if (v.poke && i == 0) begin
                    cfg_start = 1'b1;
                    cfg_mode  = 2'd3;
                    cfg_len   = 8'd0;
                end
                waitc = 0;
                while (!in_ready && waitc < 20) begin
                    tick;
                    waitc++;
                end
                if (!in_ready) check({tag, " in_ready"}, in_ready, 1'b1);
                tick;
                if (v.poke && i == 0) begin
                    cfg_start = 1'b0;
                    check({tag, " start in RUN cfg_err"}, cfg_err, 1'b0);
                    check({tag, " start in RUN in_ready"}, in_ready, 1'b1);
                end
                if (i < v.len - 1 && v.gap > 0) begin
                    in_valid = 1'b0;
                    repeat (v.gap) tick;
                    check({tag, " gap out_valid"}, out_valid, 1'b0);
                end
            end
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 10) begin
                tick;
                lat++;
            end
            check({tag, " latency"}, lat, 2);
        end
        if (sb.size() == 0) begin
            check({tag, " scoreboard entry"}, sb.size(), 1);
        end else begin
            e = sb.pop_front();
            for (int h = 0; h < v.hold; h++) begin
                out_ready = 1'b0;
                check_result({tag, " hold"}, e);
                tick;
            end
            out_ready = 1'b1;
            check_result(tag, e);
            tick;
            out_ready = 1'b0;
            check({tag, " idle after handshake busy"}, busy, 1'b0);
            check({tag, " idle after handshake out_valid"}, out_valid, 1'b0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t rv;

        //       mode  len  a      b      gap hold poke lane3   lane2   lane1   lane0
        add_vec(2'd0,  1,  8'hFF, 8'hFF, 0,  0,   0,  24'h0,  24'h0,  24'h0,  24'h00FE01);
        add_vec(2'd1,  2,  8'hA0, 8'hFF, 3,  0,   0,  24'h0,  24'h0,  24'h12C, 24'h0);
        add_vec(2'd2,  3,  8'hFF, 8'hFF, 0,  5,   0,  24'h1B, 24'h1B, 24'h1B, 24'h1B);
        add_vec(2'd0,  2,  8'hFF, 8'hFF, 0,  0,   0,  24'h0,  24'h0,  24'h0,  24'h01FC02);
        add_vec(2'd0,  1,  8'h02, 8'h03, 0,  0,   0,  24'h0,  24'h0,  24'h0,  24'h6);
        add_vec(2'd1,  0,  8'h55, 8'h55, 0,  2,   0,  24'h0,  24'h0,  24'h0,  24'h0);
        add_vec(2'd1,  4,  8'h37, 8'h5E, 1,  0,   1,  24'h0,  24'h0,  24'h3C, 24'h188);
        add_vec(2'd2,  255, 8'hE4, 8'h1B, 0, 0,   0,  24'h0,  24'h1FE, 24'h1FE, 24'h0);

        #2 nrst = 1'b0;
        #10;
        check("reset in_ready",  in_ready,  1'b0);
        check("reset out_valid", out_valid, 1'b0);
        check("reset out_acc",   out_acc,   96'd0);
        check("reset out_ovf",   out_ovf,   1'b0);
        check("reset busy",      busy,      1'b0);
        check("reset cfg_err",   cfg_err,   1'b0);
        check("reset out_acc16", out_acc16, 64'd0);
        @(posedge CLK);
        #1 nrst = 1'b1;
        tick;

        cfg_mode  = 2'd3;
        cfg_len   = 8'd5;
        cfg_start = 1'b1;
        tick;
        cfg_start = 1'b0;
        check("mode3 cfg_err pulse", cfg_err, 1'b1);
        check("mode3 busy", busy, 1'b0);
        tick;
        check("mode3 cfg_err clears", cfg_err, 1'b0);
        check("mode3 busy stays low", busy, 1'b0);

        foreach (vecs[i]) begin
            run_job($sformatf("vec%0d", i), vecs[i]);
        end

        // Abort a 4-beat INT8 job after its first beat has reached the accumulator.
        cfg_mode  = 2'd0;
        cfg_len   = 8'd4;
        cfg_start = 1'b1;
        tick;
        cfg_start = 1'b0;
        in_a = 8'd2;
        in_b = 8'd3;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        tick;
        check("pre-abort busy", busy, 1'b1);
        #1 nrst = 1'b0;
        #1;
        check("abort out_acc",   out_acc,   96'd0);
        check("abort out_valid", out_valid, 1'b0);
        check("abort busy",      busy,      1'b0);
        check("abort in_ready",  in_ready,  1'b0);
        check("abort out_ovf",   out_ovf,   1'b0);
        check("abort out_acc16", out_acc16, 64'd0);
        tick;
        tick;
        nrst = 1'b1;
        tick;

        rv.mode = 2'd0; rv.len = 1; rv.a = 8'd2; rv.b = 8'd3;
        rv.gap = 0; rv.hold = 0; rv.poke = 1'b0;
        rv.acc = 96'd6; rv.ovf = 1'b0;
        run_job("post-abort", rv);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
